vend_txn_controller: RTL

//  Per-transaction sequencer for the customer purchase datapath. Latches slot/quantity, reads price and

---
 rtl/vend_txn_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vend_txn_controller.sv
// Per-transaction purchase sequencer: fetch price/supply, collect coins, then commit the sale or refund.
// Each state's actions are registered at the edge that leaves it, so its pulses appear in the following cycle.
module vend_txn_controller #(
    parameter int N_SLOTS     = 8,
    parameter int SLOT_W      = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              sel_valid,
    input  logic [SLOT_W-1:0] sel_slot,
    input  logic [3:0]        sel_amount,
    input  logic              coin_valid,
    input  logic [6:0]        coin_val,
    input  logic              cancel,
    output logic              arr_rd_en,
    output logic [SLOT_W-1:0] arr_addr,
    input  logic [3:0]        arr_price,
    input  logic [3:0]        arr_supply,
    output logic              arr_wr_en,
    output logic [3:0]        arr_supply_wr,
    input  logic [8:0]        acc_in,
    output logic              acc_wr_en,
    output logic [8:0]        acc_out,
    output logic              dispense,
    output logic [3:0]        dispense_cnt,
    output logic              change_valid,
    output logic [6:0]        change_val,
    output logic              coin_reject,
    output logic              red_light,
    output logic              busy
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_COLLECT, S_VEND, S_CHANGE, S_REFUND, S_ERROR
    } state_t;

    state_t        state;
    logic [3:0]    amount;
    logic [3:0]    supply;
    logic [7:0]    cost;
    logic [6:0]    credit;
    logic [TW-1:0] tmo;

    logic          cust;
    logic [7:0]    fetch_cost;
    logic          slot_bad;
    logic [7:0]    coin_sum;
    logic          coin_ok;
    logic [6:0]    credit_next;
    logic [9:0]    acc_sum;

    assign cust        = (mode == 2'b01);
    assign fetch_cost  = 8'(arr_price) * 8'(amount);
    assign slot_bad    = (int'(arr_addr) >= N_SLOTS);
    assign coin_sum    = {1'b0, credit} + {1'b0, coin_val};
    assign coin_ok     = coin_valid && !coin_sum[7];
    assign credit_next = coin_ok ? coin_sum[6:0] : credit;
    assign acc_sum     = {1'b0, acc_in} + {2'b00, cost};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            amount        <= '0;
            supply        <= '0;
            cost          <= '0;
            credit        <= '0;
            tmo           <= '0;
            arr_rd_en     <= 1'b0;
            arr_addr      <= '0;
            arr_wr_en     <= 1'b0;
            arr_supply_wr <= '0;
            acc_wr_en     <= 1'b0;
            acc_out       <= '0;
            dispense      <= 1'b0;
            dispense_cnt  <= '0;
            change_valid  <= 1'b0;
            change_val    <= '0;
            coin_reject   <= 1'b0;
            red_light     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            arr_rd_en     <= 1'b0;
            arr_wr_en     <= 1'b0;
            arr_supply_wr <= '0;
            acc_wr_en     <= 1'b0;
            acc_out       <= '0;
            dispense      <= 1'b0;
            dispense_cnt  <= '0;
            change_valid  <= 1'b0;
            change_val    <= '0;
            // Coins outside COLLECT are always handed back; COLLECT overrides below.
            coin_reject   <= coin_valid;
            case (state)
                S_IDLE: begin
                    if (sel_valid && cust) begin
                        arr_addr  <= sel_slot;
                        amount    <= sel_amount;
                        arr_rd_en <= 1'b1;
                        red_light <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    cost   <= fetch_cost;
                    supply <= arr_supply;
                    tmo    <= '0;
                    if (amount == 4'd0 || amount > arr_supply || fetch_cost[7] || slot_bad) begin
                        state <= S_ERROR;
                    end else if (!cust) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    credit      <= credit_next;
                    coin_reject <= coin_valid && !coin_ok;
                    tmo         <= coin_valid ? '0 : tmo + 1'b1;
                    // A coin arriving with cancel is credited first, so it is returned in the refund.
                    if (cancel || !cust)
                        state <= S_REFUND;
                    else if ({1'b0, credit_next} >= cost)
                        state <= S_VEND;
                    else if (!coin_valid && tmo == TMO_LAST)
                        state <= S_REFUND;
                end
                S_VEND: begin
                    if (acc_sum[9]) begin
                        state <= S_ERROR;
                    end else begin
                        arr_wr_en     <= 1'b1;
                        arr_supply_wr <= supply - amount;
                        acc_wr_en     <= 1'b1;
                        acc_out       <= acc_sum[8:0];
                        dispense      <= 1'b1;
                        dispense_cnt  <= amount;
                        state         <= S_CHANGE;
                    end
                end
                S_CHANGE: begin
                    change_valid <= 1'b1;
                    change_val   <= credit - cost[6:0];
                    credit       <= '0;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                S_REFUND, S_ERROR: begin
                    change_valid <= 1'b1;
                    change_val   <= credit;
                    credit       <= '0;
                    busy         <= 1'b0;
                    if (state == S_ERROR)
                        red_light <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
